riscv_fetch: RTL and testbench

RISCV_FETCH -- requirements
Module: riscv_fetch

---
 rtl/riscv_fetch_pkg.sv | 25 ++
 rtl/riscv_fetch_fifo.sv | 59 +++++
 rtl/riscv_fetch.sv | 153 +++++++++++++++
 tb/tb_riscv_fetch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: n/a (types only).
// Backpressure: n/a.
package riscv_fetch_pkg;

    typedef enum logic [1:0] {
        STATE_BOOT  = 2'd0,
        STATE_RUN   = 2'd1,
        STATE_FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

    localparam logic [31:0] INST_BYTES = 32'd4;

    // Instructions are 4-byte aligned; any low address bit set is a fetch fault.
    function automatic logic is_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Two-entry FIFO with flush; head entry is always presented on head_dat_o.
// Latency: push visible at the head on the cycle after the push edge.
// Backpressure: none internally; caller must not push when full unless popping.
module riscv_fetch_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic [1:0]       count_o
);

    logic [1:0][WIDTH-1:0] mem_q, mem_d;
    logic [1:0]            count_q, count_d;
    logic                  pop_eff;
    logic [1:0]            wr_idx;

    // Next-state: entry 0 is the head; pops shift entry 1 down, pushes land behind the survivors.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        pop_eff = pop_i && (count_q != 2'd0);
        wr_idx  = count_q - {1'b0, pop_eff};
        if (flush_i) begin
            // A flush with a simultaneous push leaves exactly the new entry.
            count_d = {1'b0, push_i};
            if (push_i) begin
                mem_d[0] = push_dat_i;
            end
        end else begin
            if (pop_eff) begin
                mem_d[0] = mem_q[1];
            end
            if (push_i) begin
                mem_d[wr_idx[0]] = push_dat_i;
            end
            count_d = count_q + {1'b0, push_i} - {1'b0, pop_eff};
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_q   <= '0;
            count_q <= 2'd0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    assign head_dat_o = mem_q[0];
    assign count_o    = count_q;

endmodule

// File: rtl/riscv_fetch.sv
// Instruction fetch: issues in-order memory reads, buffers up to 2 instructions, handles redirects.
// Latency: a response accepted in cycle N is visible to decode in cycle N+1.
// Backpressure: requests stop when in-flight + buffered reaches 2; decode stalls via fetch_accept_i.
module riscv_fetch
    import riscv_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] reset_vector_i,
    input  logic        branch_csr_request_i,
    input  logic [31:0] branch_csr_pc_i,
    input  logic        branch_exec_request_i,
    input  logic [31:0] branch_exec_pc_i,
    output logic        mem_rd_o,
    output logic [31:0] mem_pc_o,
    input  logic        mem_accept_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_inst_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    output logic        fetch_fault_misaligned_o,
    input  logic        fetch_accept_i
);

    localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [1:0]   drop_q, drop_d;

    logic         redirect;
    logic         take_redirect;
    logic [31:0]  redirect_pc;
    logic         redirect_bad;
    logic         issue;
    logic         rsp_keep;

    // The pending-PC queue occupancy is exactly the number of outstanding requests.
    logic [1:0]   outstanding;
    logic [31:0]  pend_head;
    logic [1:0]   out_count;
    fetch_entry_t out_head;
    fetch_entry_t out_push_dat;
    logic         out_push;
    logic         out_pop;

    assign redirect      = branch_csr_request_i || branch_exec_request_i;
    assign redirect_pc   = branch_csr_request_i ? branch_csr_pc_i : branch_exec_pc_i;
    assign redirect_bad  = is_misaligned(redirect_pc);
    // BOOT is a single fixed cycle that only loads the reset vector.
    assign take_redirect = redirect && (state_q != STATE_BOOT);

    assign mem_rd_o = (state_q == STATE_RUN)
                   && (({1'b0, outstanding} + {1'b0, out_count}) < DEPTH)
                   && !redirect
                   && (drop_q == 2'd0);
    assign mem_pc_o = pc_q;
    assign issue    = mem_rd_o && mem_accept_i;

    // A response is kept only when nothing stale is still in flight and no flush is happening.
    assign rsp_keep = mem_valid_i && (drop_q == 2'd0) && !take_redirect;

    // Output FIFO input: either a fetched instruction or the single misaligned-target fault entry.
    always_comb begin
        out_push_dat = '0;
        out_push     = 1'b0;
        if (take_redirect) begin
            out_push           = redirect_bad;
            out_push_dat.pc    = redirect_pc;
            out_push_dat.instr = 32'd0;
            out_push_dat.fault = 1'b1;
        end else begin
            out_push           = rsp_keep;
            out_push_dat.pc    = pend_head;
            out_push_dat.instr = mem_inst_i;
            out_push_dat.fault = 1'b0;
        end
    end

    // The flush on a redirect wins over a decode pop in the same cycle.
    assign out_pop = fetch_valid_o && fetch_accept_i && !take_redirect;

    riscv_fetch_fifo #(
        .WIDTH (32)
    ) u_pend_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (issue),
        .push_dat_i (pc_q),
        .pop_i      (rsp_keep),
        .flush_i    (take_redirect),
        .head_dat_o (pend_head),
        .count_o    (outstanding)
    );

    riscv_fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t))
    ) u_out_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (out_push),
        .push_dat_i (out_push_dat),
        .pop_i      (out_pop),
        .flush_i    (take_redirect),
        .head_dat_o (out_head),
        .count_o    (out_count)
    );

    // Next-state for the FSM, fetch PC and stale-response drop counter.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        if (state_q == STATE_BOOT) begin
            pc_d    = reset_vector_i;
            state_d = STATE_RUN;
        end else if (take_redirect) begin
            pc_d    = redirect_pc;
            state_d = redirect_bad ? STATE_FAULT : STATE_RUN;
            // Everything in flight becomes stale; a response landing now is consumed here.
            drop_d  = drop_q + outstanding - {1'b0, mem_valid_i};
        end else begin
            if (issue) begin
                pc_d = pc_q + INST_BYTES;
            end
            if (mem_valid_i && (drop_q != 2'd0)) begin
                drop_d = drop_q - 2'd1;
            end
        end
    end

    // State, PC and drop counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= STATE_BOOT;
            pc_q    <= 32'd0;
            drop_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    assign fetch_valid_o            = (out_count != 2'd0);
    assign fetch_pc_o               = out_head.pc;
    assign fetch_instr_o            = out_head.instr;
    assign fetch_fault_misaligned_o = out_head.fault;

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed self-checking bench for riscv_fetch with an in-order memory model.
// Latency: memory answers one cycle after accept unless held off by mem_en.
// Backpressure: decode acceptance driven per test.
module tb_riscv_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] reset_vector_i;
    logic        branch_csr_request_i;
    logic [31:0] branch_csr_pc_i;
    logic        branch_exec_request_i;
    logic [31:0] branch_exec_pc_i;
    logic        mem_rd_o;
    logic [31:0] mem_pc_o;
    logic        mem_accept_i;
    logic        mem_valid_i;
    logic [31:0] mem_inst_i;
    logic        fetch_valid_o;
    logic [31:0] fetch_instr_o;
    logic [31:0] fetch_pc_o;
    logic        fetch_fault_misaligned_o;
    logic        fetch_accept_i;

    riscv_fetch #(.FIFO_DEPTH(2)) dut (
        .clk_i                    (clk_i),
        .rst_i                    (rst_i),
        .reset_vector_i           (reset_vector_i),
        .branch_csr_request_i     (branch_csr_request_i),
        .branch_csr_pc_i          (branch_csr_pc_i),
        .branch_exec_request_i    (branch_exec_request_i),
        .branch_exec_pc_i         (branch_exec_pc_i),
        .mem_rd_o                 (mem_rd_o),
        .mem_pc_o                 (mem_pc_o),
        .mem_accept_i             (mem_accept_i),
        .mem_valid_i              (mem_valid_i),
        .mem_inst_i               (mem_inst_i),
        .fetch_valid_o            (fetch_valid_o),
        .fetch_instr_o            (fetch_instr_o),
        .fetch_pc_o               (fetch_pc_o),
        .fetch_fault_misaligned_o (fetch_fault_misaligned_o),
        .fetch_accept_i           (fetch_accept_i)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    logic [31:0] rsp_q[$];
    logic [31:0] iss_q[$];
    logic [64:0] dlv_q[$];
    logic        mem_en;

    logic        s_rd, s_fv, s_ff, s_mv;
    logic [31:0] s_pc, s_fpc, s_finst;
    logic [64:0] e;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] pc);
        return pc ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] iss_at(input int i);
        if (i < iss_q.size()) return iss_q[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [64:0] dlv_at(input int i);
        if (i < dlv_q.size()) return dlv_q[i];
        return '1;
    endfunction

    // One clock cycle: sample this cycle's outputs, update the memory model, drive next response.
    task automatic cycle();
        #1;
        s_rd = mem_rd_o; s_pc = mem_pc_o; s_mv = mem_valid_i;
        s_fv = fetch_valid_o; s_fpc = fetch_pc_o; s_finst = fetch_instr_o;
        s_ff = fetch_fault_misaligned_o;
        if (mem_valid_i) void'(rsp_q.pop_front());
        if (mem_rd_o && mem_accept_i) begin
            rsp_q.push_back(mem_pc_o);
            iss_q.push_back(mem_pc_o);
        end
        if (fetch_valid_o && fetch_accept_i && !(branch_csr_request_i || branch_exec_request_i))
            dlv_q.push_back({fetch_pc_o, fetch_instr_o, fetch_fault_misaligned_o});
        @(posedge clk_i);
        #1;
        if (mem_en && rsp_q.size() > 0) begin
            mem_valid_i = 1'b1;
            mem_inst_i  = mem_data(rsp_q[0]);
        end else begin
            mem_valid_i = 1'b0;
            mem_inst_i  = 32'd0;
        end
        @(negedge clk_i);
    endtask

    task automatic clear_logs();
        iss_q.delete();
        dlv_q.delete();
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        mem_valid_i = 1'b0;
        mem_inst_i  = 32'd0;
        rsp_q.delete();
        branch_csr_request_i  = 1'b0;
        branch_exec_request_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        clear_logs();
    endtask

    task automatic redirect(input logic csr, input logic [31:0] csr_pc,
                            input logic ex, input logic [31:0] ex_pc);
        branch_csr_request_i  = csr;
        branch_csr_pc_i       = csr_pc;
        branch_exec_request_i = ex;
        branch_exec_pc_i      = ex_pc;
        cycle();
        branch_csr_request_i  = 1'b0;
        branch_exec_request_i = 1'b0;
        clear_logs();
    endtask

    initial begin
        rst_i = 1'b0;
        reset_vector_i = 32'h0000_1000;
        branch_csr_request_i = 1'b0; branch_csr_pc_i = 32'd0;
        branch_exec_request_i = 1'b0; branch_exec_pc_i = 32'd0;
        mem_accept_i = 1'b1; mem_valid_i = 1'b0; mem_inst_i = 32'd0;
        fetch_accept_i = 1'b1; mem_en = 1'b1;

        // Reset state
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_rd", mem_rd_o, 0);
        chk("rst_pc", mem_pc_o, 0);
        chk("rst_fv", fetch_valid_o, 0);
        chk("rst_finst", fetch_instr_o, 0);
        chk("rst_fpc", fetch_pc_o, 0);
        chk("rst_ff", fetch_fault_misaligned_o, 0);
        @(negedge clk_i);

        // Streaming fetch from the reset vector, checking BOOT and one-cycle latency
        rst_i = 1'b1;
        clear_logs();
        cycle(); chk("boot_no_rd", s_rd, 0);
        cycle(); chk("first_rd", s_rd, 1); chk("first_pc", s_pc, 32'h1000);
        cycle(); chk("rsp_cycle_mv", s_mv, 1); chk("rsp_cycle_fv", s_fv, 0);
        cycle(); chk("lat_fv", s_fv, 1); chk("lat_fpc", s_fpc, 32'h1000);
        chk("lat_finst", s_finst, mem_data(32'h1000));
        repeat (12) cycle();
        chk("iss0", iss_at(0), 32'h1000);
        chk("iss1", iss_at(1), 32'h1004);
        chk("iss2", iss_at(2), 32'h1008);
        for (int i = 0; i < 3; i++) begin
            e = dlv_at(i);
            chk($sformatf("dlv%0d_pc", i), e[64:33], 32'h1000 + 32'(4 * i));
            chk($sformatf("dlv%0d_inst", i), e[32:1], mem_data(32'h1000 + 32'(4 * i)));
        end

        // Decode stall: at most two buffered, no requests while full
        fetch_accept_i = 1'b0;
        do_reset();
        repeat (6) cycle();
        chk("stall_iss_n", iss_q.size(), 2);
        chk("stall_rd_low", s_rd, 0);
        chk("stall_fv", s_fv, 1);
        chk("stall_head", s_fpc, 32'h1000);
        fetch_accept_i = 1'b1;
        repeat (10) cycle();
        e = dlv_at(0); chk("stall_d0", e[64:33], 32'h1000);
        e = dlv_at(1); chk("stall_d1", e[64:33], 32'h1004);
        e = dlv_at(2); chk("stall_d2", e[64:33], 32'h1008);

        // Redirect with two requests outstanding: stale responses dropped
        mem_en = 1'b0;
        do_reset();
        repeat (4) cycle();
        chk("out2_iss_n", iss_q.size(), 2);
        redirect(1'b0, 32'd0, 1'b1, 32'h2000);
        chk("redir_no_rd", s_rd, 0);
        mem_en = 1'b1;
        repeat (10) cycle();
        chk("redir_iss0", iss_at(0), 32'h2000);
        e = dlv_at(0);
        chk("redir_d0_pc", e[64:33], 32'h2000);
        chk("redir_d0_inst", e[32:1], mem_data(32'h2000));

        // CSR and execute redirect together: CSR target wins
        redirect(1'b1, 32'h3000, 1'b1, 32'h4000);
        repeat (10) cycle();
        chk("both_iss0", iss_at(0), 32'h3000);
        e = dlv_at(0); chk("both_d0_pc", e[64:33], 32'h3000);

        // Misaligned redirect target: single fault entry, no fetches until new redirect
        fetch_accept_i = 1'b0;
        redirect(1'b0, 32'd0, 1'b1, 32'h5002);
        repeat (4) cycle();
        chk("flt_fv", s_fv, 1);
        chk("flt_pc", s_fpc, 32'h5002);
        chk("flt_bit", s_ff, 1);
        chk("flt_inst", s_finst, 0);
        chk("flt_no_iss", iss_q.size(), 0);
        fetch_accept_i = 1'b1;
        repeat (4) cycle();
        chk("flt_dlv_n", dlv_q.size(), 1);
        e = dlv_at(0); chk("flt_dlv_f", e[0], 1);
        chk("flt_drained", s_fv, 0);
        chk("flt_still_no_iss", iss_q.size(), 0);
        redirect(1'b1, 32'h100, 1'b0, 32'd0);
        repeat (10) cycle();
        chk("res_iss0", iss_at(0), 32'h100);
        e = dlv_at(0);
        chk("res_d0_pc", e[64:33], 32'h100);
        chk("res_d0_f", e[0], 0);

        // PC wraps from the top of the address space
        redirect(1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
        repeat (10) cycle();
        chk("wrap_iss0", iss_at(0), 32'hFFFF_FFFC);
        chk("wrap_iss1", iss_at(1), 32'h0);

        // Reset pulse with two requests outstanding
        mem_en = 1'b0;
        do_reset();
        repeat (4) cycle();
        chk("mrst_iss_n", iss_q.size(), 2);
        rst_i = 1'b0;
        #1;
        chk("mrst_rd", mem_rd_o, 0);
        chk("mrst_pc", mem_pc_o, 0);
        chk("mrst_fv", fetch_valid_o, 0);
        chk("mrst_fpc", fetch_pc_o, 0);
        chk("mrst_finst", fetch_instr_o, 0);
        chk("mrst_ff", fetch_fault_misaligned_o, 0);
        rsp_q.delete();
        mem_valid_i = 1'b0;
        mem_inst_i  = 32'd0;
        mem_en = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        clear_logs();
        cycle(); chk("mrst_boot", s_rd, 0);
        cycle(); chk("mrst_rd1", s_rd, 1); chk("mrst_pc1", s_pc, 32'h1000);
        repeat (6) cycle();
        e = dlv_at(0); chk("mrst_d0", e[64:33], 32'h1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
